// File: rtl/costas_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// costas_ctrl_pkg
// Shared types and constants for the Costas loop bandwidth scheduler:
//   state_t     - scheduler state (ACQ / PULL / TRACK), 2-bit encoding
//   win_class_t - classification of a completed averaging window
//   MAG_SAT     - magnitude used for the most negative error sample
// ---------------------------------------------------------------------------
package costas_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_ACQ   = 2'd0,
      ST_PULL  = 2'd1,
      ST_TRACK = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      WC_GOOD    = 2'd0,
      WC_NEUTRAL = 2'd1,
      WC_BAD     = 2'd2
   } win_class_t;

   localparam logic [15:0] MAG_SAT = 16'h7FFF;

   // Window mean strictly below lock_th is good, strictly above unlock_th bad.
   function automatic win_class_t classify_window(input logic [15:0] mean,
                                                  input int unsigned lock_th,
                                                  input int unsigned unlock_th);
      win_class_t c;
      c = WC_NEUTRAL;
      if (32'(mean) < lock_th)
         c = WC_GOOD;
      else if (32'(mean) > unlock_th)
         c = WC_BAD;
      return c;
   endfunction

endpackage

// File: rtl/costas_gain_scheduler_err_window_avg.sv
// ---------------------------------------------------------------------------
// err_window_avg
// Averages |phase error| over windows of 2^WIN_LOG2 accepted samples.
// Ports:
//   clk_16M384, rst_n_16M384 - clock, async active-low reset
//   i_clear                  - synchronous clear of the partial window;
//                              a sample accepted in the same cycle is dropped
//   i_error_tdata/tvalid     - signed phase error stream
//   o_win_mean               - mean magnitude of the last completed window
//   o_win_done               - one-cycle pulse when o_win_mean updates
// ---------------------------------------------------------------------------
module err_window_avg
   import costas_ctrl_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = 6
) (
   input  logic        clk_16M384,
   input  logic        rst_n_16M384,
   input  logic        i_clear,
   input  logic [15:0] i_error_tdata,
   input  logic        i_error_tvalid,
   output logic [15:0] o_win_mean,
   output logic        o_win_done
);

   localparam int unsigned AW = 16 + WIN_LOG2;

   logic [15:0]         w_neg;
   logic [15:0]         w_mag;
   logic [AW-1:0]       w_total;
   logic [AW-1:0]       r_acc;
   logic [WIN_LOG2-1:0] r_cnt;
   logic [15:0]         r_win_mean;
   logic                r_win_done;

   assign w_neg = ~i_error_tdata + 16'd1;

   // -32768 has no positive counterpart in 16 bits, so it saturates.
   always_comb begin
      w_mag = i_error_tdata;
      if (i_error_tdata == 16'h8000)
         w_mag = MAG_SAT;
      else if (i_error_tdata[15])
         w_mag = w_neg;
   end

   // Worst case 2^WIN_LOG2 * 32767 fits in AW bits, so no overflow.
   assign w_total = r_acc + {{WIN_LOG2{1'b0}}, w_mag};

   always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
      if (!rst_n_16M384) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_win_mean <= '0;
         r_win_done <= 1'b0;
      end else begin
         r_win_done <= 1'b0;
         if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else if (i_error_tvalid) begin
            if (&r_cnt) begin
               r_win_mean <= w_total[AW-1:WIN_LOG2];
               r_win_done <= 1'b1;
               r_acc      <= '0;
               r_cnt      <= '0;
            end else begin
               r_acc <= w_total;
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign o_win_mean = r_win_mean;
   assign o_win_done = r_win_done;

endmodule

// File: rtl/costas_gain_scheduler.sv
// ---------------------------------------------------------------------------
// costas_gain_scheduler
// Sequences the Costas loop feedback shift from acquisition to tracking
// bandwidth based on windowed mean |phase error|, and declares lock.
// Ports:
//   clk_16M384, rst_n_16M384 - clock, async active-low reset
//   error_tdata/tvalid       - signed phase error into the loop filter
//   is_bpsk                  - modulation mode; any change restarts acquisition
//   relock                   - single-cycle restart request
//   FEEDBACK_SHIFT           - registered NCO feedback shift
//   locked                   - registered lock flag
//   state                    - 0 ACQ, 1 PULL, 2 TRACK
//   win_mean, win_done       - last window mean and its update pulse
//
// state | meaning
// ------+-----------------------------------------------------------------
// ACQ   | widest bandwidth, counting consecutive good windows
// PULL  | narrowing bandwidth one shift step per good window
// TRACK | tracking bandwidth, locked; counting consecutive bad windows
// ---------------------------------------------------------------------------
module costas_gain_scheduler
   import costas_ctrl_pkg::*;
#(
   parameter int unsigned WIN_LOG2    = 6,
   parameter int unsigned ACQ_SHIFT   = 2,
   parameter int unsigned TRACK_SHIFT = 6,
   parameter int unsigned LOCK_TH     = 256,
   parameter int unsigned UNLOCK_TH   = 1024,
   parameter int unsigned ACQ_GOOD    = 2,
   parameter int unsigned LOSS_CNT    = 3
) (
   input  logic        clk_16M384,
   input  logic        rst_n_16M384,
   input  logic [15:0] error_tdata,
   input  logic        error_tvalid,
   input  logic        is_bpsk,
   input  logic        relock,
   output logic [3:0]  FEEDBACK_SHIFT,
   output logic        locked,
   output logic [1:0]  state,
   output logic [15:0] win_mean,
   output logic        win_done
);

   localparam logic [3:0] C_ACQ_SHIFT   = 4'(ACQ_SHIFT);
   localparam logic [3:0] C_TRACK_SHIFT = 4'(TRACK_SHIFT);
   localparam logic [3:0] C_ACQ_GOOD    = 4'(ACQ_GOOD);
   localparam logic [3:0] C_LOSS_CNT    = 4'(LOSS_CNT);

   state_t      r_state;
   logic [3:0]  r_shift;
   logic        r_locked;
   logic [3:0]  r_good_cnt;
   logic [3:0]  r_bad_cnt;
   logic        r_bpsk;

   logic        w_restart;
   logic [15:0] w_win_mean;
   logic        w_win_done;
   win_class_t  w_class;
   logic [3:0]  w_good_next;
   logic [3:0]  w_bad_next;
   logic [3:0]  w_shift_next;

   assign w_restart = relock | (is_bpsk ^ r_bpsk);

   err_window_avg #(
      .WIN_LOG2 (WIN_LOG2)
   ) u_err_window_avg (
      .clk_16M384     (clk_16M384),
      .rst_n_16M384   (rst_n_16M384),
      .i_clear        (w_restart),
      .i_error_tdata  (error_tdata),
      .i_error_tvalid (error_tvalid),
      .o_win_mean     (w_win_mean),
      .o_win_done     (w_win_done)
   );

   assign w_class      = classify_window(w_win_mean, LOCK_TH, UNLOCK_TH);
   assign w_good_next  = r_good_cnt + 4'd1;
   assign w_bad_next   = r_bad_cnt + 4'd1;
   assign w_shift_next = r_shift + 4'd1;

   always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
      if (!rst_n_16M384) begin
         r_state    <= ST_ACQ;
         r_shift    <= C_ACQ_SHIFT;
         r_locked   <= 1'b0;
         r_good_cnt <= '0;
         r_bad_cnt  <= '0;
         r_bpsk     <= 1'b0;
      end else begin
         r_bpsk <= is_bpsk;
         if (w_restart) begin
            // Overrides any window decision arriving this cycle.
            r_state    <= ST_ACQ;
            r_shift    <= C_ACQ_SHIFT;
            r_locked   <= 1'b0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
         end else begin
            case (r_state)
               ST_ACQ: begin
                  r_locked <= 1'b0;
                  if (w_win_done) begin
                     if (w_class == WC_GOOD) begin
                        if (w_good_next == C_ACQ_GOOD) begin
                           r_state    <= ST_PULL;
                           r_shift    <= C_ACQ_SHIFT + 4'd1;
                           r_good_cnt <= '0;
                        end else begin
                           r_good_cnt <= w_good_next;
                        end
                     end else begin
                        r_good_cnt <= '0;
                     end
                  end
               end
               ST_PULL: begin
                  r_locked <= 1'b0;
                  if (w_win_done) begin
                     if (w_class == WC_GOOD) begin
                        r_shift <= w_shift_next;
                        if (w_shift_next == C_TRACK_SHIFT) begin
                           r_state  <= ST_TRACK;
                           r_locked <= 1'b1;
                        end
                     end else if (w_class == WC_BAD) begin
                        r_state <= ST_ACQ;
                        r_shift <= C_ACQ_SHIFT;
                     end
                  end
               end
               ST_TRACK: begin
                  r_locked <= 1'b1;
                  if (w_win_done) begin
                     if (w_class == WC_BAD) begin
                        if (w_bad_next == C_LOSS_CNT) begin
                           r_state   <= ST_ACQ;
                           r_shift   <= C_ACQ_SHIFT;
                           r_locked  <= 1'b0;
                           r_bad_cnt <= '0;
                        end else begin
                           r_bad_cnt <= w_bad_next;
                        end
                     end else begin
                        r_bad_cnt <= '0;
                     end
                  end
               end
               default: begin
                  // Unused encoding: fall back to acquisition.
                  r_state    <= ST_ACQ;
                  r_shift    <= C_ACQ_SHIFT;
                  r_locked   <= 1'b0;
                  r_good_cnt <= '0;
                  r_bad_cnt  <= '0;
               end
            endcase
         end
      end
   end

   assign FEEDBACK_SHIFT = r_shift;
   assign locked         = r_locked;
   assign state          = r_state;
   assign win_mean       = w_win_mean;
   assign win_done       = w_win_done;

endmodule

// File: tb/tb_costas_gain_scheduler.sv
module tb_costas_gain_scheduler;

   localparam int W   = 4;
   localparam int N   = 16;
   localparam int ACQ = 2;
   localparam int TRK = 6;
   localparam int LTH = 256;
   localparam int UTH = 1024;
   localparam int AG  = 2;
   localparam int LC  = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] err;
   logic        vld, bpsk, relock;
   logic [3:0]  fb_shift;
   logic        locked;
   logic [1:0]  state;
   logic [15:0] win_mean;
   logic        win_done;

   always #5 clk = ~clk;

   costas_gain_scheduler #(.WIN_LOG2(W)) dut (
      .clk_16M384     (clk),
      .rst_n_16M384   (rst_n),
      .error_tdata    (err),
      .error_tvalid   (vld),
      .is_bpsk        (bpsk),
      .relock         (relock),
      .FEEDBACK_SHIFT (fb_shift),
      .locked         (locked),
      .state          (state),
      .win_mean       (win_mean),
      .win_done       (win_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a list of window magnitudes plus the shift value.
   // The scheduler state is implied by the shift (ACQ at ACQ, TRACK at TRK).
   int m_samples[$];
   int m_shift, m_good, m_bad, m_mean;
   bit m_done, m_bpsk;
   bit cur_bpsk;

   function automatic int mag(input logic [15:0] d);
      if (d == 16'h8000) return 32767;
      if (d[15]) return 65536 - int'(d);
      return int'(d);
   endfunction

   task automatic model_reset();
      m_samples.delete();
      m_shift = ACQ; m_good = 0; m_bad = 0; m_mean = 0;
      m_done = 0; m_bpsk = 0;
   endtask

   task automatic window_decision(input int mean);
      bit good, bad;
      good = mean < LTH;
      bad  = mean > UTH;
      if (m_shift == ACQ) begin
         m_good = good ? m_good + 1 : 0;
         if (m_good == AG) begin m_shift = ACQ + 1; m_good = 0; end
      end else if (m_shift == TRK) begin
         m_bad = bad ? m_bad + 1 : 0;
         if (m_bad == LC) begin m_shift = ACQ; m_bad = 0; end
      end else begin
         if (good) m_shift++;
         else if (bad) m_shift = ACQ;
      end
   endtask

   task automatic model_edge(input logic [15:0] d, input bit v, input bit b, input bit rl);
      bit rs;
      int s;
      rs = rl || (b != m_bpsk);
      if (rs) begin m_shift = ACQ; m_good = 0; m_bad = 0; end
      else if (m_done) window_decision(m_mean);
      m_done = 0;
      if (rs) m_samples.delete();
      else if (v) begin
         m_samples.push_back(mag(d));
         if (m_samples.size() == N) begin
            s = 0;
            foreach (m_samples[i]) s += m_samples[i];
            m_mean = s / N;
            m_done = 1;
            m_samples.delete();
         end
      end
      m_bpsk = b;
   endtask

   task automatic check_outputs();
      check("win_done", int'(win_done), int'(m_done));
      check("win_mean", int'(win_mean), m_mean);
      check("shift",    int'(fb_shift), m_shift);
      check("locked",   int'(locked),   int'(m_shift == TRK));
      check("state",    int'(state),    (m_shift == ACQ) ? 0 : (m_shift == TRK) ? 2 : 1);
   endtask

   task automatic step(input logic [15:0] d, input bit v, input bit rl);
      err = d; vld = v; bpsk = cur_bpsk; relock = rl;
      @(posedge clk);
      model_edge(d, v, cur_bpsk, rl);
      #1;
      check_outputs();
   endtask

   function automatic logic [15:0] signed_val(input int m);
      logic [15:0] d;
      if (m >= 32768) return 16'h8000;
      d = 16'(m);
      if ($urandom_range(1) == 1) d = ~d + 16'd1;
      return d;
   endfunction

   task automatic send_level(input int lo, input int hi, input int ncyc, input int vpct);
      for (int i = 0; i < ncyc; i++)
         step(signed_val(int'($urandom_range(hi, lo))), $urandom_range(99) < vpct, 1'b0);
   endtask

   task automatic idle(input int ncyc);
      for (int i = 0; i < ncyc; i++) step(16'd0, 1'b0, 1'b0);
   endtask

   task automatic send_random(input int nseg);
      int lvl, lo, hi, len, vp;
      bit rl;
      for (int s = 0; s < nseg; s++) begin
         lvl = $urandom_range(3);
         case (lvl)
            0, 1: begin lo = 0;    hi = LTH - 1; end
            2:    begin lo = LTH;  hi = UTH;     end
            default: begin lo = UTH + 1; hi = 32768; end
         endcase
         len = $urandom_range(120, 16);
         vp  = $urandom_range(100, 30);
         for (int i = 0; i < len; i++) begin
            rl = ($urandom_range(299) == 0);
            if ($urandom_range(399) == 0) cur_bpsk = ~cur_bpsk;
            step(signed_val(int'($urandom_range(hi, lo))), $urandom_range(99) < vp, rl);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; err = '0; vld = 1'b0; bpsk = 1'b0; relock = 1'b0;
      cur_bpsk = 1'b0;
      model_reset();
      #12;
      check_outputs();
      #10 rst_n = 1'b1;

      // Acquisition to lock: six aligned windows of |100|.
      send_level(100, 100, 96, 100);
      check("acq_locked", int'(locked), 1);

      // Lock loss: two bad, one neutral (restarts count), three bad.
      send_level(2000, 2000, 32, 100);
      send_level(500, 500, 16, 100);
      send_level(2000, 2000, 48, 100);
      idle(2);
      check("loss_state", int'(state), 0);

      // Saturation in PULL returns to ACQ.
      step(16'd0, 1'b0, 1'b1);
      send_level(100, 100, 32, 100);
      idle(2);
      check("pull_entered", int'(state), 1);
      for (int i = 0; i < N; i++) step(16'h8000, 1'b1, 1'b0);
      idle(2);
      check("sat_mean", int'(win_mean), 32767);
      check("sat_to_acq", int'(fb_shift), ACQ);

      // Gappy valid: every third cycle.
      for (int i = 0; i < 3 * N; i++) step(signed_val(100), (i % 3) == 2, 1'b0);
      idle(1);

      // Mode change mid-window while tracking.
      step(16'd0, 1'b0, 1'b1);
      send_level(100, 100, 96, 100);
      send_level(100, 100, 7, 100);
      cur_bpsk = ~cur_bpsk;
      step(signed_val(100), 1'b1, 1'b0);
      check("mode_unlock", int'(locked), 0);
      send_level(100, 100, N + 2, 100);

      // Threshold boundaries: 255 good, 1024/256 neutral, 1025 bad.
      step(16'd0, 1'b0, 1'b1);
      send_level(255, 255, 32, 100);
      send_level(1024, 1024, 16, 100);
      send_level(256, 256, 16, 100);
      idle(2);
      check("neutral_hold", int'(fb_shift), ACQ + 1);
      send_level(1025, 1025, 16, 100);
      idle(2);

      send_random(30);

      // Asynchronous reset during PULL.
      step(16'd0, 1'b0, 1'b1);
      send_level(100, 100, 32, 100);
      idle(2);
      send_level(100, 100, 5, 100);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1 check_outputs();
      #2 rst_n = 1'b1;

      send_random(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
